// File: rtl/lincomb_calc_if.sv
// lincomb_calc_if: request/result handshake bundle for lincomb_calc.
// master = producer/consumer side, slave = the calculator itself.
interface lincomb_calc_if #(
  parameter int DW = 4,
  parameter int KW = 4
);
  localparam int OW = DW + KW + 1;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [KW-1:0] ka;
  logic [KW-1:0] kb;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] y;
  logic          busy;

  modport master (
    output in_valid, a, b, ka, kb, out_ready,
    input  in_ready, out_valid, y, busy
  );

  modport slave (
    input  in_valid, a, b, ka, kb, out_ready,
    output in_ready, out_valid, y, busy
  );
endinterface

// File: rtl/lincomb_calc.sv
// lincomb_calc: y = ka*a + kb*b by iterative shift-add, one coefficient bit
// per cycle, valid/ready on both sides.
// Optional macro LINCOMB_EARLY_TERM_EN: leave CALC as soon as the remaining
// coefficient bits are all zero (data-dependent latency). Undefined: CALC is
// always exactly KW cycles.
module lincomb_calc #(
  parameter int DW = 4,
  parameter int KW = 4
) (
  input logic            clk,
  input logic            rst,
  lincomb_calc_if.slave  bus
);
  localparam int OW = DW + KW + 1;
  localparam int CW = (KW > 1) ? $clog2(KW) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [OW-1:0] a_sh;
  logic [OW-1:0] b_sh;
  logic [KW-1:0] ka_r;
  logic [KW-1:0] kb_r;
  logic [OW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [OW-1:0] y_r;
  logic          out_valid_r;
  logic          busy_r;

  logic [OW-1:0] add_a;
  logic [OW-1:0] add_b;
  logic [OW-1:0] acc_next;
  logic [KW-1:0] ka_nx;
  logic [KW-1:0] kb_nx;
  logic          calc_last;

  // in_ready is low while reset is held, then follows the IDLE state
  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = out_valid_r;
  assign bus.y         = y_r;
  assign bus.busy      = busy_r;

  // One shift-add step: partial products, next accumulator and the exit test
  always_comb begin
    add_a     = {OW{1'b0}};
    add_b     = {OW{1'b0}};
    if (ka_r[0]) begin
      add_a = a_sh;
    end else begin
      add_a = {OW{1'b0}};
    end
    if (kb_r[0]) begin
      add_b = b_sh;
    end else begin
      add_b = {OW{1'b0}};
    end
    acc_next  = acc + add_a + add_b;
    ka_nx     = ka_r >> 1;
    kb_nx     = kb_r >> 1;
`ifdef LINCOMB_EARLY_TERM_EN
    calc_last = (cnt == CW'(KW - 1)) || ((ka_nx | kb_nx) == {KW{1'b0}});
`else
    calc_last = (cnt == CW'(KW - 1));
`endif
  end

  // Control FSM and datapath registers; reset drops any in-flight request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_sh        <= {OW{1'b0}};
      b_sh        <= {OW{1'b0}};
      ka_r        <= {KW{1'b0}};
      kb_r        <= {KW{1'b0}};
      acc         <= {OW{1'b0}};
      cnt         <= {CW{1'b0}};
      y_r         <= {OW{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh   <= {{(OW-DW){1'b0}}, bus.a};
            b_sh   <= {{(OW-DW){1'b0}}, bus.b};
            ka_r   <= bus.ka;
            kb_r   <= bus.kb;
            acc    <= {OW{1'b0}};
            cnt    <= {CW{1'b0}};
            busy_r <= 1'b1;
            state  <= CALC;
          end else begin
            state  <= IDLE;
          end
        end
        CALC: begin
          acc  <= acc_next;
          a_sh <= a_sh << 1;
          b_sh <= b_sh << 1;
          ka_r <= ka_nx;
          kb_r <= kb_nx;
          cnt  <= cnt + CW'(1);
          if (calc_last) begin
            y_r         <= acc_next;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            state       <= CALC;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end else begin
            state       <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lincomb_calc.sv
// tb_lincomb_calc: directed checks of lincomb_calc (DW=KW=4) with immediate
// assertions; expected latencies follow LINCOMB_EARLY_TERM_EN when defined.
module tb_lincomb_calc;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  lincomb_calc_if #(.DW(4), .KW(4)) bus ();

  lincomb_calc #(.DW(4), .KW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one request (caller guarantees in_ready), then wait for out_valid.
  // exp_lat < 0 skips the latency check.
  task automatic do_req(input string tag, input logic [3:0] va, input logic [3:0] vb,
                        input logic [3:0] vka, input logic [3:0] vkb,
                        input int exp_y, input int exp_lat);
    int lat;
    chk({tag, "_rdy"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.a = va; bus.b = vb; bus.ka = vka; bus.kb = vkb;
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_busy"}, bus.busy, 1);
    chk({tag, "_nrdy"}, bus.in_ready, 0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    if (exp_lat >= 0) chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_y"}, bus.y, exp_y);
  endtask

  int lat_one;
  int lat_two;
  int lat_zero;

  initial begin
    logic [3:0] ra, rb, rka, rkb;
    int gap;
    errors = 0;
    checks = 0;
`ifdef LINCOMB_EARLY_TERM_EN
    lat_one = 1; lat_two = 2; lat_zero = 1;
`else
    lat_one = 4; lat_two = 4; lat_zero = 4;
`endif
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = 4'd0; bus.b = 4'd0; bus.ka = 4'd0; bus.kb = 4'd0;
    #2;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_busy", bus.busy, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("idle_in_ready", bus.in_ready, 1);

    // 12*15 + 5*15 with out_ready held high
    bus.out_ready = 1'b1;
    do_req("t255", 4'd15, 4'd15, 4'd12, 4'd5, 255, 4);
    chk("t255_busy_done", bus.busy, 1);
    tick();
    chk("t255_ov_fall", bus.out_valid, 0);
    chk("t255_rdy_rise", bus.in_ready, 1);
    chk("t255_y_kept", bus.y, 255);

    // maximum operands: 9-bit result without wrap
    do_req("tmax", 4'd15, 4'd15, 4'd15, 4'd15, 450, 4);
    tick();
    chk("tmax_ov_fall", bus.out_valid, 0);

    // backpressure: 12*3 + 5*7 = 71 held while a second request is offered
    bus.out_ready = 1'b0;
    do_req("t71", 4'd3, 4'd7, 4'd12, 4'd5, 71, 4);
    bus.in_valid = 1'b1;
    bus.a = 4'd2; bus.b = 4'd2; bus.ka = 4'd1; bus.kb = 4'd1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_ov_held", bus.out_valid, 1);
      chk("bp_y_held", bus.y, 71);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_hs_ov", bus.out_valid, 0);
    chk("bp_hs_busy", bus.busy, 0);
    chk("bp_hs_rdy", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_next_acc", bus.busy, 1);
    begin
      int lat;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      chk("bp_next_lat", lat, lat_one);
      chk("bp_next_y", bus.y, 4);
    end
    tick();

    // reset two cycles into CALC drops the request
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 4'd15; bus.b = 4'd15; bus.ka = 4'd12; bus.kb = 4'd5;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", bus.out_valid, 0);
    chk("mid_rst_y", bus.y, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_rdy", bus.in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    bus.out_ready = 1'b1;
    do_req("t2", 4'd1, 4'd1, 4'd1, 4'd1, 2, lat_one);
    tick();

    // coefficient-dependent latency cases
    do_req("t17", 4'd5, 4'd6, 4'd1, 4'd2, 17, lat_two);
    tick();
    do_req("tz", 4'd9, 4'd9, 4'd0, 4'd0, 0, lat_zero);
    tick();
    chk("tz_ov_fall", bus.out_valid, 0);

    // 20 random requests, random consumer stalls
    for (int n = 0; n < 20; n++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rka = 4'($urandom_range(0, 15));
      rkb = 4'($urandom_range(0, 15));
      bus.out_ready = 1'b0;
      do_req("rnd", ra, rb, rka, rkb, int'(rka) * int'(ra) + int'(rkb) * int'(rb), -1);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("rnd_hold", bus.out_valid, 1);
      end
      bus.out_ready = 1'b1;
      tick();
      chk("rnd_ov_fall", bus.out_valid, 0);
      chk("rnd_y_kept", bus.y, int'(rka) * int'(ra) + int'(rkb) * int'(rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lincomb_calc.md
# lincomb_calc

Runtime-coefficient two-term linear combination unit: computes y = ka*a + kb*b by iterative shift-add, one coefficient bit per cycle. It generalises the fixed 12a+5b calculator to parametrised operand and coefficient widths, with coefficients supplied per transaction. Both sides use a valid/ready handshake, so it sits between a pipelined producer and consumer in the datapath.

## Interface
- DW, 4: width of operands a, b
- KW, 4: width of coefficients ka, kb; also the full-iteration cycle count
- OW (localparam) = DW+KW+1: result width; holds the max (2^DW-1)(2^KW-1)*2 exactly
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high (one clock; reset is asynchronous and active-high)
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept request
- a  in  DW  operand A, unsigned
- b  in  DW  operand B, unsigned
- ka  in  KW  coefficient for A, unsigned
- kb  in  KW  coefficient for B, unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- y  out  OW  result ka*a + kb*b, unsigned
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, CALC, DONE. Reset state IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready: capture a_sh=a (zero-extended to OW), b_sh=b, ka_r=ka, kb_r=kb, acc=0, cnt=0; go CALC.
- CALC, each cycle: acc += (ka_r[0] ? a_sh : 0) + (kb_r[0] ? b_sh : 0); a_sh<<=1; b_sh<<=1; ka_r>>=1; kb_r>>=1; cnt++.
- CALC exit: after the cycle with cnt==KW-1, load y<=acc_next, go DONE.
- DONE: out_valid=1, y stable. On out_ready: go IDLE. y keeps last result afterwards.
- in_ready=0 in CALC and DONE; no new request accepted until the result is consumed.
- Arithmetic unsigned, all accumulation at OW bits; no overflow possible by construction.
- in_valid while in_ready=0 is ignored; inputs sampled only at the accept edge.

## Timing
- Reset values: in_ready=0 while rst high, then 1 (IDLE); out_valid=0; y=0; busy=0; all internal regs 0.
- Latency: request accepted at edge T; out_valid high from edge T+KW, without EARLY_TERM_EN.
- Throughput: at most one result per KW+2 cycles when out_ready is held high (accept, KW CALC, DONE handshake, IDLE).
- out_valid held, y stable, until the out_ready edge; out_valid falls on that edge, and in_ready rises on the same edge.
- rst asserted in any state: immediate return to IDLE, out_valid=0, y=0; the in-flight request is dropped with no output.
- in_valid high in cycle of DONE handshake: not accepted (in_ready=0 that cycle); accepted next cycle.

## Configuration
- LINCOMB_EARLY_TERM_EN defined: CALC also exits after any cycle where (ka_r|kb_r) after the shift is 0. CALC length = max(1, index of MSB of (ka|kb) + 1) cycles; ka=kb=0 gives 1 CALC cycle, y=0.
- Undefined: CALC always exactly KW cycles, data-independent latency.

## Test plan
- Reset, then a=15,b=15,ka=12,kb=5, out_ready=1 -> y=255, out_valid rises 4 edges after accept (DW=KW=4); busy high throughout.
- a=3,b=7,ka=12,kb=5 -> y=71; max case a=b=ka=kb=15 -> y=450 (9 bits, no wrap).
- Backpressure: out_ready=0 for 6 cycles after out_valid -> y and out_valid held, in_ready=0, second in_valid ignored; out_ready=1 -> handshake, next request accepted the following cycle.
- Reset mid-CALC (2 cycles after accept) -> out_valid=0, y=0, busy=0 immediately; next request a=1,b=1,ka=1,kb=1 -> y=2.
- With LINCOMB_EARLY_TERM_EN: ka=1,kb=2,a=5,b=6 -> y=17 after 2 CALC cycles; ka=kb=0 -> y=0 after 1; without the macro both take 4.
- Back-to-back: 20 random requests with random out_ready gaps -> every y matches ka*a+kb*b in order, no duplicates or drops.
